// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline sequencer: PC source select, controller state and the
// bundled per-cycle control word, plus constructors for the common control patterns.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    PcSeq    = 2'd0,
    PcJump   = 2'd1,
    PcJr     = 2'd2,
    PcBranch = 2'd3
  } pc_sel_t;

  typedef enum logic [1:0] {
    StRun,
    StLuStall,
    StDrain,
    StHalted
  } ctrl_state_t;

  typedef struct packed {
    logic    pc_en;
    pc_sel_t pc_sel;
    logic    ifid_en;
    logic    idex_en;
    logic    exmem_en;
    logic    memwb_en;
    logic    ifid_flush;
    logic    idex_flush;
    logic    exmem_flush;
  } ctrl_out_t;

  // Everything frozen: no latch moves, PC holds.
  function automatic ctrl_out_t ctrl_idle();
    ctrl_out_t c;
    c = '0;
    c.pc_sel = PcSeq;
    return c;
  endfunction

  // Every latch advances and the PC loads from the given source.
  function automatic ctrl_out_t ctrl_all_en(input pc_sel_t sel);
    ctrl_out_t c;
    c = '0;
    c.pc_en    = 1'b1;
    c.pc_sel   = sel;
    c.ifid_en  = 1'b1;
    c.idex_en  = 1'b1;
    c.exmem_en = 1'b1;
    c.memwb_en = 1'b1;
    return c;
  endfunction

  // Load-use bubble: hold PC and IF/ID, inject a NOP into ID/EX.
  function automatic ctrl_out_t ctrl_lu_stall();
    ctrl_out_t c;
    c = ctrl_all_en(PcSeq);
    c.pc_en      = 1'b0;
    c.ifid_en    = 1'b0;
    c.idex_flush = 1'b1;
    return c;
  endfunction

  // Taken branch resolved in MEM squashes the three younger instructions.
  function automatic ctrl_out_t ctrl_branch();
    ctrl_out_t c;
    c = ctrl_all_en(PcBranch);
    c.ifid_flush  = 1'b1;
    c.idex_flush  = 1'b1;
    c.exmem_flush = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Handshake bundle between the pipeline sequencer (ctrl), the datapath (dp) and a bench (tb).
interface pipeline_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  import pipeline_ctrl_pkg::*;

  logic             ihit;
  logic             dmem_req;
  logic             dhit;
  logic             load_use;
  logic             jump;
  logic             jr;
  logic             branch_taken;
  logic             halt_mem;

  logic             pc_en;
  pc_sel_t          pc_sel;
  logic             ifid_en;
  logic             idex_en;
  logic             exmem_en;
  logic             memwb_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_flush;
  logic             halt;
  logic [CNT_W-1:0] stall_cnt;

  modport ctrl (
    input  ihit, dmem_req, dhit, load_use, jump, jr, branch_taken, halt_mem,
    output pc_en, pc_sel, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, halt, stall_cnt
  );

  modport dp (
    output ihit, dmem_req, dhit, load_use, jump, jr, branch_taken, halt_mem,
    input  pc_en, pc_sel, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, halt, stall_cnt
  );

  modport tb (
    output ihit, dmem_req, dhit, load_use, jump, jr, branch_taken, halt_mem,
    input  pc_en, pc_sel, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, halt, stall_cnt
  );

endinterface

// File: rtl/pipeline_ctrl_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module pipeline_ctrl_sat_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  output logic [Width-1:0] q
);

  logic [Width-1:0] q_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      q_q <= '0;
    end else if (en && (q_q != '1)) begin
      q_q <= q_q + Width'(1);
    end
  end

  assign q = q_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: arbitrates cache misses, halt, redirects
// and load-use bubbles into per-latch enables/flushes and the PC source select.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned LU_STALL_CYCLES = 1,
  parameter int unsigned CNT_W           = 16
) (
  input  logic         CLK,
  input  logic         nRST,
  pipeline_ctrl_if.ctrl bus
);

  localparam int unsigned LuW = (LU_STALL_CYCLES > 1) ? $clog2(LU_STALL_CYCLES) + 1 : 1;

  ctrl_state_t    state_q, state_d;
  logic [LuW-1:0] lu_cnt_q, lu_cnt_d;
  ctrl_out_t      ctl;
  logic           dmiss;
  logic           stall_en;

  // A pending data access freezes the whole pipe ahead of every other request.
  assign dmiss = bus.dmem_req && !bus.dhit;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q  <= StRun;
      lu_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      lu_cnt_q <= lu_cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    lu_cnt_d = lu_cnt_q;
    unique case (state_q)
      StRun: begin
        if (dmiss) begin
          state_d = StRun;
        end else if (bus.halt_mem) begin
          state_d = StDrain;
        end else if (bus.branch_taken || bus.jr) begin
          state_d = StRun;
        end else if (bus.load_use && (LU_STALL_CYCLES > 1)) begin
          state_d  = StLuStall;
          lu_cnt_d = LuW'(LU_STALL_CYCLES - 1);
        end
      end
      StLuStall: begin
        if (dmiss) begin
          state_d = StLuStall;
        end else if (bus.branch_taken || (lu_cnt_q <= LuW'(1))) begin
          state_d  = StRun;
          lu_cnt_d = '0;
        end else begin
          lu_cnt_d = lu_cnt_q - LuW'(1);
        end
      end
      StDrain:  state_d = StHalted;
      StHalted: state_d = StHalted;
      default:  state_d = StRun;
    endcase
  end

  always_comb begin
    ctl = ctrl_idle();
    if (nRST) begin
      unique case (state_q)
        StRun: begin
          if (dmiss) begin
            ctl = ctrl_idle();
          end else if (bus.halt_mem) begin
            ctl.exmem_en    = 1'b1;
            ctl.exmem_flush = 1'b1;
            ctl.memwb_en    = 1'b1;
          end else if (bus.branch_taken) begin
            ctl = ctrl_branch();
          end else if (bus.jr) begin
            ctl            = ctrl_all_en(PcJr);
            ctl.ifid_flush = 1'b1;
            ctl.idex_flush = 1'b1;
          end else if (bus.load_use) begin
            ctl = ctrl_lu_stall();
          end else if (bus.jump) begin
            ctl            = ctrl_all_en(PcJump);
            ctl.ifid_flush = 1'b1;
          end else if (!bus.ihit) begin
            ctl            = ctrl_all_en(PcSeq);
            ctl.pc_en      = 1'b0;
            ctl.ifid_flush = 1'b1;
          end else begin
            ctl = ctrl_all_en(PcSeq);
          end
        end
        StLuStall: begin
          if (dmiss) begin
            ctl = ctrl_idle();
          end else if (bus.branch_taken) begin
            ctl = ctrl_branch();
          end else begin
            ctl = ctrl_lu_stall();
          end
        end
        StDrain:  ctl.memwb_en = 1'b1;
        StHalted: ctl = ctrl_idle();
        default:  ctl = ctrl_idle();
      endcase
    end
  end

  assign bus.pc_en       = ctl.pc_en;
  assign bus.pc_sel      = ctl.pc_sel;
  assign bus.ifid_en     = ctl.ifid_en;
  assign bus.idex_en     = ctl.idex_en;
  assign bus.exmem_en    = ctl.exmem_en;
  assign bus.memwb_en    = ctl.memwb_en;
  assign bus.ifid_flush  = ctl.ifid_flush;
  assign bus.idex_flush  = ctl.idex_flush;
  assign bus.exmem_flush = ctl.exmem_flush;
  assign bus.halt        = nRST && (state_q == StHalted);

  // Only count stalls of a live CPU; drain and halt are not stalls.
  assign stall_en = nRST && ((state_q == StRun) || (state_q == StLuStall)) && !ctl.pc_en;

  pipeline_ctrl_sat_counter #(
    .Width (CNT_W)
  ) u_stall_cnt (
    .clk (CLK),
    .clr (!nRST),
    .en  (stall_en),
    .q   (bus.stall_cnt)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed scoreboard bench for pipeline_ctrl: one instance with single-cycle load-use bubbles,
// one with three-cycle bubbles and a narrow counter to reach saturation.
module tb_pipeline_ctrl;

  // Input word: {ihit, dmem_req, dhit, load_use, jump, jr, branch_taken, halt_mem}
  localparam logic [7:0] I_NOP      = 8'b1000_0000;
  localparam logic [7:0] I_NOIHIT   = 8'b0000_0000;
  localparam logic [7:0] I_LU       = 8'b1001_0000;
  localparam logic [7:0] I_MISS_BR  = 8'b1100_0010;
  localparam logic [7:0] I_HIT_BR   = 8'b1110_0010;
  localparam logic [7:0] I_BR_LU_J  = 8'b1001_1010;
  localparam logic [7:0] I_JR_J     = 8'b1000_1100;
  localparam logic [7:0] I_J_NOIHIT = 8'b0000_1000;
  localparam logic [7:0] I_MISS     = 8'b1100_0000;
  localparam logic [7:0] I_BR       = 8'b1000_0010;
  localparam logic [7:0] I_HALT_J   = 8'b1000_1001;

  // Control word: {pc_en, pc_sel[1:0], ifid/idex/exmem/memwb en, ifid/idex/exmem flush, halt}
  localparam logic [11:0] C_IDLE  = 12'b0_00_0000_000_0;
  localparam logic [11:0] C_RUN   = 12'b1_00_1111_000_0;
  localparam logic [11:0] C_LU    = 12'b0_00_0111_010_0;
  localparam logic [11:0] C_BR    = 12'b1_11_1111_111_0;
  localparam logic [11:0] C_JR    = 12'b1_10_1111_110_0;
  localparam logic [11:0] C_JMP   = 12'b1_01_1111_100_0;
  localparam logic [11:0] C_MISS  = 12'b0_00_1111_100_0;
  localparam logic [11:0] C_HLTM  = 12'b0_00_0011_001_0;
  localparam logic [11:0] C_DRAIN = 12'b0_00_0001_000_0;
  localparam logic [11:0] C_HALT  = 12'b0_00_0000_000_1;

  typedef struct {
    int          dut;
    logic [11:0] ctl;
    logic [15:0] cnt;
    string       tag;
  } exp_t;

  logic clk;
  logic nrst;
  logic rst_level;
  int   tests_run;
  int   failures;
  exp_t sb[$];

  pipeline_ctrl_if #(.CNT_W(16)) ia ();
  pipeline_ctrl_if #(.CNT_W(4))  ib ();

  pipeline_ctrl #(
    .LU_STALL_CYCLES (1),
    .CNT_W           (16)
  ) dut_a (
    .CLK  (clk),
    .nRST (nrst),
    .bus  (ia)
  );

  pipeline_ctrl #(
    .LU_STALL_CYCLES (3),
    .CNT_W           (4)
  ) dut_b (
    .CLK  (clk),
    .nRST (nrst),
    .bus  (ib)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_a(input logic [7:0] v);
    {ia.ihit, ia.dmem_req, ia.dhit, ia.load_use, ia.jump, ia.jr, ia.branch_taken,
     ia.halt_mem} = v;
  endtask

  task automatic drive_b(input logic [7:0] v);
    {ib.ihit, ib.dmem_req, ib.dhit, ib.load_use, ib.jump, ib.jr, ib.branch_taken,
     ib.halt_mem} = v;
  endtask

  // One cycle: drive the selected instance (the other idles with a clean fetch), queue the
  // expectation, then compare mid-cycle.
  task automatic step(input int dut, input logic [7:0] v, input logic [11:0] ctl,
                      input logic [15:0] cnt, input string tag);
    exp_t        e;
    logic [11:0] obs_ctl;
    logic [15:0] obs_cnt;
    @(posedge clk);
    #1;
    nrst = rst_level;
    if (dut == 0) begin
      drive_a(v);
      drive_b(I_NOP);
    end else begin
      drive_a(I_NOP);
      drive_b(v);
    end
    e.dut = dut;
    e.ctl = ctl;
    e.cnt = cnt;
    e.tag = tag;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    if (e.dut == 0) begin
      obs_ctl = {ia.pc_en, ia.pc_sel, ia.ifid_en, ia.idex_en, ia.exmem_en, ia.memwb_en,
                 ia.ifid_flush, ia.idex_flush, ia.exmem_flush, ia.halt};
      obs_cnt = ia.stall_cnt;
    end else begin
      obs_ctl = {ib.pc_en, ib.pc_sel, ib.ifid_en, ib.idex_en, ib.exmem_en, ib.memwb_en,
                 ib.ifid_flush, ib.idex_flush, ib.exmem_flush, ib.halt};
      obs_cnt = {12'd0, ib.stall_cnt};
    end
    tests_run++;
    assert (obs_ctl === e.ctl) else begin
      failures++;
      $error("FAIL %s ctl: observed=%b expected=%b", e.tag, obs_ctl, e.ctl);
    end
    tests_run++;
    assert (obs_cnt === e.cnt) else begin
      failures++;
      $error("FAIL %s stall_cnt: observed=%0d expected=%0d", e.tag, obs_cnt, e.cnt);
    end
  endtask

  initial begin
    tests_run = 0;
    failures  = 0;
    nrst      = 1'b0;
    rst_level = 1'b0;
    drive_a(I_NOP);
    drive_b(I_NOP);

    // Power-on reset
    step(0, I_NOP, C_IDLE, 16'd0, "por_a");
    step(1, I_NOP, C_IDLE, 16'd0, "por_b");

    // Reset asserted while instance B sits in a load-use stall
    rst_level = 1'b1;
    step(1, I_LU,  C_LU,   16'd0, "rst_mid_lu_enter");
    rst_level = 1'b0;
    step(1, I_NOP, C_IDLE, 16'd1, "rst_mid_lu_force");
    step(1, I_NOP, C_IDLE, 16'd0, "rst_mid_lu_hold1");
    step(1, I_NOP, C_IDLE, 16'd0, "rst_mid_lu_hold2");
    rst_level = 1'b1;
    step(1, I_NOP, C_RUN,  16'd0, "rst_release_run");
    step(1, I_NOP, C_RUN,  16'd0, "rst_release_run2");

    // Single-cycle load-use bubble
    step(0, I_LU,  C_LU,  16'd0, "lu1_bubble");
    step(0, I_NOP, C_RUN, 16'd1, "lu1_resume");
    step(0, I_NOP, C_RUN, 16'd1, "lu1_steady");

    // Three-cycle load-use bubble
    step(1, I_LU,  C_LU,  16'd0, "lu3_c1");
    step(1, I_NOP, C_LU,  16'd1, "lu3_c2");
    step(1, I_NOP, C_LU,  16'd2, "lu3_c3");
    step(1, I_NOP, C_RUN, 16'd3, "lu3_resume");
    step(1, I_NOP, C_RUN, 16'd3, "lu3_steady");

    // Data miss holds off a taken branch until dhit
    for (int i = 0; i < 4; i++) begin
      step(0, I_MISS_BR, C_IDLE, 16'(1 + i), "dmiss_freeze");
    end
    step(0, I_HIT_BR, C_BR,  16'd5, "dhit_branch");
    step(0, I_NOP,    C_RUN, 16'd5, "after_branch");

    // Branch beats simultaneous load-use and jump
    step(0, I_BR_LU_J, C_BR, 16'd5, "br_lu_jump");

    // Redirect priorities and fetch miss
    step(0, I_JR_J,     C_JR,   16'd5, "jr_over_jump");
    step(0, I_J_NOIHIT, C_JMP,  16'd5, "jump_no_ihit");
    step(0, I_NOIHIT,   C_MISS, 16'd5, "imiss");
    step(0, I_NOP,      C_RUN,  16'd6, "imiss_resume");

    // Branch preempts a multi-cycle load-use stall
    step(1, I_LU,  C_LU,  16'd3, "lu_br_enter");
    step(1, I_BR,  C_BR,  16'd4, "lu_br_preempt");
    step(1, I_NOP, C_RUN, 16'd4, "lu_br_run");

    // Data miss freezes a load-use stall without consuming a bubble
    step(1, I_LU,   C_LU,   16'd4, "lu_dmiss_enter");
    step(1, I_MISS, C_IDLE, 16'd5, "lu_dmiss_freeze");
    step(1, I_NOP,  C_LU,   16'd6, "lu_dmiss_b2");
    step(1, I_NOP,  C_LU,   16'd7, "lu_dmiss_b3");
    step(1, I_NOP,  C_RUN,  16'd8, "lu_dmiss_run");

    // 4-bit stall counter saturates at 15
    for (int i = 0; i < 10; i++) begin
      step(1, I_NOIHIT, C_MISS, (8 + i > 15) ? 16'd15 : 16'(8 + i), "sat_count");
    end
    step(1, I_NOP, C_RUN, 16'd15, "sat_hold");

    // Halt: drain, then sticky halt with counter frozen
    step(0, I_HALT_J, C_HLTM,  16'd6, "halt_mem");
    step(0, I_NOP,    C_DRAIN, 16'd7, "drain");
    for (int i = 0; i < 10; i++) begin
      step(0, (i % 2 == 0) ? 8'b0000_0011 : 8'b1001_1000, C_HALT, 16'd7, "halted_sticky");
    end

    // Only reset leaves HALTED
    rst_level = 1'b0;
    step(0, I_NOP, C_IDLE, 16'd7, "halt_rst_force");
    step(0, I_NOP, C_IDLE, 16'd0, "halt_rst_clear");
    rst_level = 1'b1;
    step(0, I_NOP, C_RUN,  16'd0, "halt_rst_run");

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
